// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF fetches and MEM loads/stores onto a byte-wide
// synchronous RAM bus. Each request is split into byte transfers.
// MEM wins over IF, but a transaction that has started is never preempted.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   if_req_i/if_addr_i   fetch request (level) and word address
//   if_inst_o/if_done_o  assembled instruction and its one-cycle valid pulse
//   if_stallreq_o        fetch outstanding (if_req_i & ~if_done_o)
//   mem_req_i/mem_we_i   load/store request (level) and direction
//   mem_width_i          0 byte, 1 half, 2/3 word
//   mem_addr_i/mem_wdata_i  byte address and store data
//   mem_rdata_o/mem_done_o  zero-extended load data and completion pulse
//   mem_stallreq_o       access outstanding (mem_req_i & ~mem_done_o)
//   ram_a_o/ram_wr_o/ram_dout_o/ram_din_i  byte RAM bus (1-cycle read latency)
module mem_ctrl #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [31:0]       if_inst_o,
   output logic              if_done_o,
   output logic              if_stallreq_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_width_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic              mem_stallreq_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    nbytes_q, nbytes_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   if_inst_q, if_inst_d;
   logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
   logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
   logic                ram_wr_q, ram_wr_d;
   logic [7:0]          ram_dout_q, ram_dout_d;
   logic                if_done_c, mem_done_c;
   logic [DATA_W-1:0]   rd_word_c;
   logic [1:0]          cap_idx_c;
   logic [1:0]          wr_idx_c;

   // Transfer length for a MEM request.
   function automatic logic [CNT_W-1:0] width_bytes(input logic [1:0] w);
      case (w)
         2'd0:    width_bytes = CNT_W'(1);
         2'd1:    width_bytes = CNT_W'(2);
         default: width_bytes = CNT_W'(4);
      endcase
   endfunction

   // The last byte is still on ram_din_i in the done cycle, so merge it here.
   assign rd_word_c = data_q | (DATA_W'(ram_din_i) << {2'(nbytes_q - CNT_W'(1)), 3'b000});
   assign cap_idx_c = 2'(cnt_q - CNT_W'(1));
   assign wr_idx_c  = 2'(cnt_q + CNT_W'(1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         nbytes_q    <= '0;
         wdata_q     <= '0;
         data_q      <= '0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
         ram_a_q     <= '0;
         ram_wr_q    <= 1'b0;
         ram_dout_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         nbytes_q    <= nbytes_d;
         wdata_q     <= wdata_d;
         data_q      <= data_d;
         if_inst_q   <= if_inst_d;
         mem_rdata_q <= mem_rdata_d;
         ram_a_q     <= ram_a_d;
         ram_wr_q    <= ram_wr_d;
         ram_dout_q  <= ram_dout_d;
      end
   end

   // Arbitration and byte sequencing.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      nbytes_d    = nbytes_q;
      wdata_d     = wdata_q;
      data_d      = data_q;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
      ram_a_d     = ram_a_q;
      ram_wr_d    = ram_wr_q;
      ram_dout_d  = ram_dout_q;
      if_done_c   = 1'b0;
      mem_done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            ram_a_d    = '0;
            ram_wr_d   = 1'b0;
            ram_dout_d = '0;
            cnt_d      = '0;
            data_d     = '0;
            if (mem_req_i) begin
               nbytes_d = width_bytes(mem_width_i);
               ram_a_d  = mem_addr_i;
               wdata_d  = mem_wdata_i;
               if (mem_we_i) begin
                  state_d    = MEM_WR;
                  ram_wr_d   = 1'b1;
                  ram_dout_d = mem_wdata_i[7:0];
               end else begin
                  state_d = MEM_RD;
               end
            end else if (if_req_i) begin
               nbytes_d = CNT_W'(4);
               ram_a_d  = if_addr_i;
               state_d  = IF_RD;
            end
         end
         IF_RD, MEM_RD: begin
            if (cnt_q == nbytes_q) begin
               if (state_q == IF_RD) begin
                  if_done_c = 1'b1;
                  if_inst_d = rd_word_c;
               end else begin
                  mem_done_c  = 1'b1;
                  mem_rdata_d = rd_word_c;
               end
               state_d = IDLE;
               ram_a_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               // ram_din_i carries the byte addressed in the previous cycle.
               if (cnt_q != '0) begin
                  data_d[{cap_idx_c, 3'b000} +: 8] = ram_din_i;
               end
               if ((cnt_q + CNT_W'(1)) < nbytes_q) begin
                  ram_a_d = ram_a_q + ADDR_W'(1);
               end
            end
         end
         MEM_WR: begin
            if (cnt_q == (nbytes_q - CNT_W'(1))) begin
               mem_done_c = 1'b1;
               state_d    = IDLE;
               ram_a_d    = '0;
               ram_wr_d   = 1'b0;
               ram_dout_d = '0;
            end else begin
               cnt_d      = cnt_q + CNT_W'(1);
               ram_a_d    = ram_a_q + ADDR_W'(1);
               ram_dout_d = wdata_q[{wr_idx_c, 3'b000} +: 8];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign if_done_o      = if_done_c;
   assign mem_done_o     = mem_done_c;
   assign if_inst_o      = if_done_c  ? rd_word_c : if_inst_q;
   assign mem_rdata_o    = mem_done_c ? rd_word_c : mem_rdata_q;
   assign if_stallreq_o  = if_req_i  & ~if_done_c;
   assign mem_stallreq_o = mem_req_i & ~mem_done_c;
   assign ram_a_o        = ram_a_q;
   assign ram_wr_o       = ram_wr_q;
   assign ram_dout_o     = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a 64 KiB byte RAM model (low 16 address bits).
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_inst;
   logic        if_done;
   logic        if_stallreq;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_width;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        mem_stallreq;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;

   logic [7:0]  ram [0:65535];
   logic        poke_en;
   logic [15:0] poke_a;
   logic [7:0]  poke_d;
   int          wr_cnt = 0;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_inst_o(if_inst),
      .if_done_o(if_done), .if_stallreq_o(if_stallreq),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_width_i(mem_width),
      .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
      .mem_done_o(mem_done), .mem_stallreq_o(mem_stallreq),
      .ram_a_o(ram_a), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout), .ram_din_i(ram_din)
   );

   // Synchronous byte RAM: write on ram_wr, read data one cycle after address.
   always @(posedge clk) begin
      if (poke_en) ram[poke_a] <= poke_d;
      else if (ram_wr) begin
         ram[ram_a[15:0]] <= ram_dout;
         wr_cnt <= wr_cnt + 1;
      end
      ram_din <= ram[ram_a[15:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      poke_en = 1'b1; poke_a = a; poke_d = d;
      tick();
      poke_en = 1'b0;
   endtask

   // Full IF word fetch from idle: addresses in cycles 0-3, done in cycle 4.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
      if_req = 1'b1; if_addr = addr;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("fetch_addr", ram_a, addr + 32'(k));
         chk("fetch_wr", 32'(ram_wr), 32'd0);
         chk("fetch_done_early", 32'(if_done), 32'd0);
         chk("fetch_stall", 32'(if_stallreq), 32'd1);
         tick();
      end
      chk("fetch_done", 32'(if_done), 32'd1);
      chk("fetch_inst", if_inst, exp);
      chk("fetch_stall_done", 32'(if_stallreq), 32'd0);
      if_req = 1'b0;
      tick();
      chk("fetch_done_clr", 32'(if_done), 32'd0);
      chk("fetch_inst_hold", if_inst, exp);
   endtask

   // Store of n bytes of 0xDEADBEEF; done on the last byte cycle.
   task automatic store(input logic [1:0] w, input int n, input logic [31:0] addr);
      logic [7:0] eb [4];
      eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE;
      mem_req = 1'b1; mem_we = 1'b1; mem_width = w; mem_addr = addr; mem_wdata = 32'hDEADBEEF;
      tick();
      for (int k = 0; k < n; k++) begin
         chk("st_addr", ram_a, addr + 32'(k));
         chk("st_wr", 32'(ram_wr), 32'd1);
         chk("st_dout", 32'(ram_dout), 32'(eb[k]));
         chk("st_done", 32'(mem_done), (k == n - 1) ? 32'd1 : 32'd0);
         if (k == n - 1) mem_req = 1'b0;
         tick();
      end
      chk("st_wr_off", 32'(ram_wr), 32'd0);
      chk("st_idle_addr", ram_a, 32'd0);
      for (int k = 0; k < n; k++) chk("st_ram", 32'(ram[16'(addr + 32'(k))]), 32'(eb[k]));
   endtask

   initial begin
      int w0;
      rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
      mem_width = '0; mem_addr = '0; mem_wdata = '0; poke_en = 1'b0; poke_a = '0; poke_d = '0;
      poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'hA0); poke(16'h0103, 8'h00);
      poke(16'h0104, 8'h78); poke(16'h0105, 8'h56); poke(16'h0106, 8'h34); poke(16'h0107, 8'h12);
      poke(16'h3001, 8'h34); poke(16'h3002, 8'h12);
      poke(16'h2100, 8'h00); poke(16'h2101, 8'h00); poke(16'h2102, 8'h00); poke(16'h2103, 8'h00);
      poke(16'hFFFE, 8'hAA); poke(16'hFFFF, 8'hBB); poke(16'h0000, 8'hCC); poke(16'h0001, 8'hDD);

      // Reset state
      chk("rst_ram_a", ram_a, 32'd0);
      chk("rst_ram_wr", 32'(ram_wr), 32'd0);
      chk("rst_ram_dout", 32'(ram_dout), 32'd0);
      chk("rst_if_inst", if_inst, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      chk("rst_if_done", 32'(if_done), 32'd0);
      chk("rst_mem_done", 32'(mem_done), 32'd0);
      rst = 1'b0;
      tick();

      // IF word fetch
      fetch(32'h0000_0100, 32'h00A0_0513);

      // Load half from 0x3001
      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd1; mem_addr = 32'h3001;
      tick();
      chk("ldh_a0", ram_a, 32'h3001);
      chk("ldh_done0", 32'(mem_done), 32'd0);
      chk("ldh_stall0", 32'(mem_stallreq), 32'd1);
      tick();
      chk("ldh_a1", ram_a, 32'h3002);
      chk("ldh_done1", 32'(mem_done), 32'd0);
      tick();
      chk("ldh_done2", 32'(mem_done), 32'd1);
      chk("ldh_rdata", mem_rdata, 32'h0000_1234);
      chk("ldh_stall2", 32'(mem_stallreq), 32'd0);
      mem_req = 1'b0;
      tick();
      chk("ldh_done_clr", 32'(mem_done), 32'd0);
      chk("ldh_hold", mem_rdata, 32'h0000_1234);

      // Stores: byte, half, word, width 3 as word
      store(2'd0, 1, 32'h2000);
      store(2'd1, 2, 32'h2000);
      store(2'd2, 4, 32'h2000);
      store(2'd3, 4, 32'h2010);
      chk("st_keeps_rdata", mem_rdata, 32'h0000_1234);

      // Simultaneous requests: MEM byte load first, IF one idle cycle later
      if_req = 1'b1; if_addr = 32'h100;
      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h3002;
      tick();
      chk("arb_mem_a", ram_a, 32'h3002);
      chk("arb_if_stall0", 32'(if_stallreq), 32'd1);
      chk("arb_mem_stall0", 32'(mem_stallreq), 32'd1);
      tick();
      chk("arb_mem_done", 32'(mem_done), 32'd1);
      chk("arb_rdata", mem_rdata, 32'h0000_0012);
      chk("arb_if_stall1", 32'(if_stallreq), 32'd1);
      chk("arb_if_done1", 32'(if_done), 32'd0);
      mem_req = 1'b0;
      tick();
      chk("arb_idle_a", ram_a, 32'd0);
      chk("arb_if_stall_idle", 32'(if_stallreq), 32'd1);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("arb_if_a", ram_a, 32'h100 + 32'(k));
         tick();
      end
      chk("arb_if_done", 32'(if_done), 32'd1);
      chk("arb_if_inst", if_inst, 32'h00A0_0513);
      if_req = 1'b0;
      tick();

      // MEM arrives in IF cycle 2: IF finishes first
      if_req = 1'b1; if_addr = 32'h104;
      tick(); tick(); tick();
      chk("nopre_a2", ram_a, 32'h106);
      mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd0; mem_addr = 32'h2005; mem_wdata = 32'h0000_00A5;
      tick();
      chk("nopre_a3", ram_a, 32'h107);
      chk("nopre_wr3", 32'(ram_wr), 32'd0);
      chk("nopre_mstall3", 32'(mem_stallreq), 32'd1);
      tick();
      chk("nopre_if_done", 32'(if_done), 32'd1);
      chk("nopre_inst", if_inst, 32'h1234_5678);
      chk("nopre_mem_done4", 32'(mem_done), 32'd0);
      chk("nopre_mstall4", 32'(mem_stallreq), 32'd1);
      if_req = 1'b0;
      tick();
      chk("nopre_idle_done", 32'(mem_done), 32'd0);
      chk("nopre_idle_mstall", 32'(mem_stallreq), 32'd1);
      tick();
      chk("nopre_st_a", ram_a, 32'h2005);
      chk("nopre_st_dout", 32'(ram_dout), 32'hA5);
      chk("nopre_st_done", 32'(mem_done), 32'd1);
      mem_req = 1'b0;
      tick();
      chk("nopre_ram", 32'(ram[16'h2005]), 32'hA5);

      // Reset in the middle of a word store after two bytes
      w0 = wr_cnt;
      mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd2; mem_addr = 32'h2100; mem_wdata = 32'h1122_3344;
      tick();
      chk("rstw_dout0", 32'(ram_dout), 32'h44);
      tick();
      chk("rstw_dout1", 32'(ram_dout), 32'h33);
      chk("rstw_done1", 32'(mem_done), 32'd0);
      rst = 1'b1; mem_req = 1'b0;
      tick();
      chk("rstw_wr", 32'(ram_wr), 32'd0);
      chk("rstw_a", ram_a, 32'd0);
      chk("rstw_dout", 32'(ram_dout), 32'd0);
      chk("rstw_done", 32'(mem_done), 32'd0);
      chk("rstw_inst", if_inst, 32'd0);
      chk("rstw_rdata", mem_rdata, 32'd0);
      rst = 1'b0;
      tick();
      chk("rstw_wr_count", 32'(wr_cnt - w0), 32'd2);
      chk("rstw_ram0", 32'(ram[16'h2100]), 32'h44);
      chk("rstw_ram1", 32'(ram[16'h2101]), 32'h33);
      chk("rstw_ram2", 32'(ram[16'h2102]), 32'h00);
      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h2101;
      tick();
      chk("rstw_fresh_a", ram_a, 32'h2101);
      tick();
      chk("rstw_fresh_done", 32'(mem_done), 32'd1);
      chk("rstw_fresh_rdata", mem_rdata, 32'h0000_0033);
      mem_req = 1'b0;
      tick();

      // Address wrap
      fetch(32'hFFFF_FFFE, 32'hDDCC_BBAA);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
